bd_rx_host_bridge: RTL and testbench
====================================

# bd_rx_host_bridge

Downstream stage of the register field in the BD receive path. Buffers decoded byte pairs (BD_DATA_0, BD_DATA_1) in a small FIFO and serialises them to the host as an 8-bit valid/ready byte stream, byte 0 first. Drives the receive interrupt `int_rx_host` and tracks overflow when the host drains too slowly.

## Interface
- DEPTH, 4: FIFO depth in byte pairs; power of two, ≥2.
- IRQ_LEVEL, 1: occupancy (pairs) at or above which `int_rx_host` asserts; 1..DEPTH.

- G_CLK_RX  in  1  receive clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- BD_DATA_0  in  8  decoded first byte of a pair.
- BD_DATA_1  in  8  decoded second byte of a pair.
- pair_valid  in  1  single-cycle strobe; BD_DATA_0/1 valid this cycle.
- data_out  out  8  byte to host.
- valid_out  out  1  data_out valid.
- ready_out  in  1  host accepts data_out.
- int_rx_host  out  1  receive interrupt, level.
- overflow  out  1  sticky: a pair was dropped.
- ovf_clr  in  1  single-cycle clear of `overflow`.
- fill_level  out  $clog2(DEPTH+1)  pairs stored, including the pair being sent.

## Operation
- FIFO: DEPTH entries × 16 bits ({BD_DATA_1, BD_DATA_0}). Write/read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A separate occupancy counter drives full/empty.
- Push: on `pair_valid`, if count<DEPTH, or a pop occurs in the same cycle.
  - If full and no pop, the pair is dropped, `overflow` sets and count is unchanged.
- Output FSM, states IDLE, BYTE0, BYTE1:
  - IDLE → BYTE0 when count≠0.
  - BYTE0: data_out = head[7:0], valid_out=1. On valid_out&&ready_out, go to BYTE1.
  - BYTE1: data_out = head[15:8], valid_out=1.
    - On handshake: pop the head and decrement count.
    - Then go to BYTE0 if count-after-pop≠0, else IDLE.
  - In IDLE, valid_out=0 and data_out=8'h00.
- Handshake rules:
  - Once valid_out is high, it and data_out hold until the handshake.
  - The host may hold ready_out high permanently; bytes then stream back-to-back.
- Simultaneous push and pop: count unchanged, both pointers advance.
- `overflow`: set has priority over ovf_clr in the same cycle.
- `int_rx_host`: registered, equal to (count_next ≥ IRQ_LEVEL) || overflow_next.
- Reset (reset==0 at the edge), at any point including mid-pair:
  - Pointers, count, fill_level, overflow and int_rx_host go to 0.
  - FSM goes to IDLE; valid_out=0, data_out=0.
  - Stored and in-flight pairs are discarded. FIFO RAM contents need not be cleared.

## Timing
- Push at edge N → count/fill_level updated after N.
  - valid_out high in cycle N+1 if the FSM was IDLE (FSM leaves IDLE at edge N+1).
  - Minimum latency pair_valid → first valid_out = 2 cycles.
- Byte rate: up to 1 byte/cycle. A continuously full FIFO drains at 1 pair per 2 cycles.
- `int_rx_host` updates at the same edge as count, so it follows a push by 1 cycle.
- `overflow` is visible 1 cycle after the dropped `pair_valid`.
- `ovf_clr` takes effect at the next edge.
- All outputs are registered or decoded from registered state only. There is no combinational path from ready_out or pair_valid to any output.

## Structure
- Shared package `bd_pkg`:
  - typedef `bd_pair_t` (struct {logic [7:0] b1, b0;}).
  - enum `bd_tx_state_e` {IDLE, BYTE0, BYTE1}.
  - Default constants BD_RX_FIFO_DEPTH=4 and BD_RX_IRQ_LEVEL=1.
- One sub-module `bd_pair_fifo`: parameterised sync FIFO with push/pop/full/empty/count and no output register.
- FSM, overflow flag and interrupt live in the top.

## Test plan
- Single pair 8'hA5/8'h3C, ready_out=1:
  - valid_out in cycle 2 after the strobe; data_out A5 then 3C on consecutive cycles.
  - int_rx_host high 1 cycle after the strobe, low after the 3C handshake.
- Backpressure: ready_out=0 for 10 cycles after valid_out rises → data_out holds A5, valid_out holds 1; release → A5, 3C accepted.
- Fill to DEPTH=4 with ready_out=0, then push a 5th pair:
  - Dropped; overflow=1; fill_level=4; int_rx_host=1.
  - Drain yields exactly pairs 1–4 in order.
  - ovf_clr → overflow=0.
- Full FIFO, push on the BYTE1 handshake cycle → pair accepted, count stays 4, overflow stays 0.
- Pointer wrap: 10 pairs 8'h00..8'h13 streamed with ready_out=1 → byte sequence 00,01,…,13 with no gaps beyond the startup latency.
- reset=0 while in BYTE1 with 3 pairs stored → next cycle valid_out=0, fill_level=0, int_rx_host=0, overflow=0; a following pair is delivered normally.

Source files
------------

// File: rtl/bd_pkg.sv
// Shared types and defaults for the BD receive path.
package bd_pkg;

   typedef struct packed {
      logic [7:0] b1;
      logic [7:0] b0;
   } bd_pair_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BYTE0 = 2'd1,
      BYTE1 = 2'd2
   } bd_tx_state_e;

   localparam int unsigned BD_RX_FIFO_DEPTH = 4;
   localparam int unsigned BD_RX_IRQ_LEVEL  = 1;

endpackage

// File: rtl/bd_pair_fifo.sv
// Synchronous FIFO of byte pairs; head is read straight from the array (no output register).
module bd_pair_fifo
   import bd_pkg::*;
#(
   parameter int unsigned Depth = BD_RX_FIFO_DEPTH
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  bd_pair_t                     wdata_i,
   output bd_pair_t                     rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_ok, pop_ok;
   bd_pair_t        mem_q [Depth];

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok = push_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/bd_rx_host_bridge.sv
// Buffers decoded BD byte pairs and serialises them to the host, byte 0 first,
// with a level interrupt and a sticky overflow flag.
module bd_rx_host_bridge
   import bd_pkg::*;
#(
   parameter int unsigned DEPTH     = BD_RX_FIFO_DEPTH,
   parameter int unsigned IRQ_LEVEL = BD_RX_IRQ_LEVEL
) (
   input  logic                          G_CLK_RX,
   input  logic                          reset,
   input  logic [7:0]                    BD_DATA_0,
   input  logic [7:0]                    BD_DATA_1,
   input  logic                          pair_valid,
   output logic [7:0]                    data_out,
   output logic                          valid_out,
   input  logic                          ready_out,
   output logic                          int_rx_host,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic [$clog2(DEPTH+1)-1:0]    fill_level
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);

   bd_tx_state_e    state_q, state_d;
   bd_pair_t        head, wdata;
   logic            full, empty, pop, drop, push_ok;
   logic [CntW-1:0] count, cnt_next;
   logic            ovf_q, ovf_d, irq_q, irq_d;

   assign wdata.b1 = BD_DATA_1;
   assign wdata.b0 = BD_DATA_0;
   assign pop      = (state_q == BYTE1) && ready_out;
   assign drop     = pair_valid && full && !pop;
   assign push_ok  = pair_valid && !drop;

   bd_pair_fifo #(
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i   (G_CLK_RX),
      .rst_ni  (reset),
      .push_i  (pair_valid),
      .pop_i   (pop),
      .wdata_i (wdata),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_comb begin
      cnt_next = count;
      if (push_ok && !pop)      cnt_next = count + CntW'(1);
      else if (!push_ok && pop) cnt_next = count - CntW'(1);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!empty) state_d = BYTE0;
         BYTE0:   if (ready_out) state_d = BYTE1;
         BYTE1: begin
            // A pair pushed during the pop keeps the stream going without an IDLE bubble.
            if (ready_out) state_d = (cnt_next != '0) ? BYTE0 : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid_out = 1'b0;
      data_out  = 8'h00;
      unique case (state_q)
         BYTE0: begin
            valid_out = 1'b1;
            data_out  = head.b0;
         end
         BYTE1: begin
            valid_out = 1'b1;
            data_out  = head.b1;
         end
         default: ;
      endcase
   end

   assign ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   assign irq_d = (cnt_next >= CntW'(IRQ_LEVEL)) || ovf_d;

   always_ff @(posedge G_CLK_RX) begin
      if (!reset) begin
         state_q <= IDLE;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         irq_q   <= irq_d;
      end
   end

   assign overflow    = ovf_q;
   assign int_rx_host = irq_q;
   assign fill_level  = count;

endmodule

// File: tb/tb_bd_rx_host_bridge.sv
// Self-checking bench for bd_rx_host_bridge: vector table plus directed corner sequences.
module tb_bd_rx_host_bridge;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] d0, d1;
   logic       pv, ready, clr;
   logic [7:0] data_out;
   logic       valid_out, int_rx_host, overflow;
   logic [2:0] fill_level;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       pv;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       rdy;
      logic       exp_v;
      logic [7:0] exp_d;
      int         exp_fill;
      logic       exp_int;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         cyc_q[$];

   always #5 clk = ~clk;

   bd_rx_host_bridge #(
      .DEPTH     (4),
      .IRQ_LEVEL (1)
   ) dut (
      .G_CLK_RX    (clk),
      .reset       (reset),
      .BD_DATA_0   (d0),
      .BD_DATA_1   (d1),
      .pair_valid  (pv),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .ready_out   (ready),
      .int_rx_host (int_rx_host),
      .overflow    (overflow),
      .ovf_clr     (clr),
      .fill_level  (fill_level)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      pv = 1'b0; ready = 1'b0; clr = 1'b0;
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      pv = 1'b1; d0 = a; d1 = b;
      step();
      pv = 1'b0;
   endtask

   task automatic collect(input int n);
      got_q.delete();
      ready = 1'b1;
      repeat (n) begin
         if (valid_out) got_q.push_back(data_out);
         step();
      end
      ready = 1'b0;
   endtask

   task automatic cmp_bytes(input string nm);
      chk({nm, " count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s byte%0d", nm, i), got_q[i], exp_q[i]);
   endtask

   function automatic vec_t mk(logic p, logic [7:0] a, logic [7:0] b, logic r,
                               logic ev, logic [7:0] ed, int ef, logic ei);
      vec_t v;
      v.pv = p; v.d0 = a; v.d1 = b; v.rdy = r;
      v.exp_v = ev; v.exp_d = ed; v.exp_fill = ef; v.exp_int = ei;
      return v;
   endfunction

   initial begin
      pv = 1'b0; d0 = 8'h00; d1 = 8'h00; ready = 1'b0; clr = 1'b0;
      reset = 1'b0;
      step();
      step();
      chk("rst valid", valid_out, 0);
      chk("rst data", data_out, 0);
      chk("rst fill", fill_level, 0);
      chk("rst int", int_rx_host, 0);
      chk("rst ovf", overflow, 0);
      reset = 1'b1;

      // Single pair with ready held high, then the same pair under 10 cycles of backpressure.
      vecs.push_back(mk(1, 8'hA5, 8'h3C, 1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'hA5, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h3C, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0));
      vecs.push_back(mk(1, 8'hA5, 8'h3C, 0, 0, 8'h00, 0, 0));
      vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 1));
      for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 8'h00, 8'h00, 0, 1, 8'hA5, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'hA5, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h3C, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0));

      foreach (vecs[i]) begin
         pv = vecs[i].pv; d0 = vecs[i].d0; d1 = vecs[i].d1; ready = vecs[i].rdy;
         chk($sformatf("vec%0d valid", i), valid_out, vecs[i].exp_v);
         chk($sformatf("vec%0d data", i), data_out, vecs[i].exp_d);
         chk($sformatf("vec%0d fill", i), fill_level, vecs[i].exp_fill);
         chk($sformatf("vec%0d int", i), int_rx_host, vecs[i].exp_int);
         chk($sformatf("vec%0d ovf", i), overflow, 0);
         step();
      end

      // Overflow: fifth pair into a full FIFO is dropped.
      do_reset();
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 8'h20 + 8'(i));
      push(8'hEE, 8'hFF);
      chk("ovf flag", overflow, 1);
      chk("ovf fill", fill_level, 4);
      chk("ovf int", int_rx_host, 1);
      chk("ovf head", data_out, 8'h10);
      exp_q = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
      collect(12);
      cmp_bytes("ovf drain");
      chk("ovf sticky", overflow, 1);
      chk("ovf int sticky", int_rx_host, 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("ovf clr", overflow, 0);
      chk("ovf clr int", int_rx_host, 0);

      // Full FIFO, push on the BYTE1 handshake cycle is accepted.
      do_reset();
      for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 8'h50 + 8'(i));
      chk("b1push fill0", fill_level, 4);
      ready = 1'b1;
      step();
      chk("b1push byte1", data_out, 8'h50);
      pv = 1'b1; d0 = 8'h99; d1 = 8'h98;
      step();
      pv = 1'b0; ready = 1'b0;
      chk("b1push fill", fill_level, 4);
      chk("b1push ovf", overflow, 0);
      exp_q = '{8'h41, 8'h51, 8'h42, 8'h52, 8'h43, 8'h53, 8'h99, 8'h98};
      collect(12);
      cmp_bytes("b1push drain");

      // Pointer wrap: 10 pairs, one every other cycle, ready held high.
      do_reset();
      ready = 1'b1;
      got_q.delete();
      cyc_q.delete();
      for (int c = 0; c < 30; c++) begin
         pv = (c % 2 == 0) && (c < 20);
         d0 = 8'(c);
         d1 = 8'(c + 1);
         if (valid_out) begin
            got_q.push_back(data_out);
            cyc_q.push_back(c);
         end
         step();
      end
      pv = 1'b0; ready = 1'b0;
      chk("wrap count", got_q.size(), 20);
      if (cyc_q.size() > 0) chk("wrap latency", cyc_q[0], 2);
      for (int k = 0; k < got_q.size(); k++) begin
         chk($sformatf("wrap byte%0d", k), got_q[k], k);
         chk($sformatf("wrap gap%0d", k), cyc_q[k] - cyc_q[0], k);
      end

      // Reset while in BYTE1 with 3 pairs stored and overflow set.
      do_reset();
      for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), 8'h70 + 8'(i));
      push(8'hEE, 8'hFF);
      ready = 1'b1;
      step();
      step();
      step();
      ready = 1'b0;
      chk("mid fill", fill_level, 3);
      chk("mid ovf", overflow, 1);
      chk("mid valid", valid_out, 1);
      chk("mid data", data_out, 8'h71);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mid rst valid", valid_out, 0);
      chk("mid rst data", data_out, 0);
      chk("mid rst fill", fill_level, 0);
      chk("mid rst int", int_rx_host, 0);
      chk("mid rst ovf", overflow, 0);
      push(8'h5A, 8'hC3);
      chk("post valid c1", valid_out, 0);
      chk("post int c1", int_rx_host, 1);
      step();
      chk("post valid c2", valid_out, 1);
      exp_q = '{8'h5A, 8'hC3};
      collect(6);
      cmp_bytes("post");
      chk("post fill", fill_level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
